// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 4;

  localparam bit REQ0 = 1'b0;
  localparam bit REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Latched request payload: operation, address and write data
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } op_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Requester handshakes plus the single memory port; slave = arbiter, master = environment.
interface memory_arbiter_if;
  import mem_arb_pkg::*;

  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    output ack0, ack1, rdata, busy, mem_write, mem_address, mem_data_in
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    input  ack0, ack1, rdata, busy, mem_write, mem_address, mem_data_in
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select; MEM_ARB_ROUND_ROBIN_EN selects alternating tie-break,
// otherwise requester 0 wins ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant
);

  always_comb begin
    grant = REQ0;
    if (req0 && req1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      grant = ~last_grant;
`else
      grant = REQ0;
`endif
    end else if (req1) begin
      grant = REQ1;
    end
  end

`ifndef MEM_ARB_ROUND_ROBIN_EN
  // History is tracked by the parent but has no effect under fixed priority
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates two requesters onto one synchronous 8x4 memory: IDLE -> ISSUE -> RESP per access.
// Tie-break mode is set by MEM_ARB_ROUND_ROBIN_EN (see mem_arb_pick).
module memory_arbiter
  import mem_arb_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  memory_arbiter_if.slave  bus
);

  state_t state, state_nxt;
  logic   winner_q, winner_nxt;
  logic   last_grant_q, last_grant_nxt;
  op_t    op_q, op_nxt;
  op_t    op0, op1;
  logic   grant;

  assign op0 = '{we: bus.we0, addr: bus.addr0, wdata: bus.wdata0};
  assign op1 = '{we: bus.we1, addr: bus.addr1, wdata: bus.wdata1};

  mem_arb_pick u_pick (
    .req0       (bus.req0),
    .req1       (bus.req1),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      winner_q     <= REQ0;
      last_grant_q <= REQ1;
      op_q         <= '0;
    end else begin
      state        <= state_nxt;
      winner_q     <= winner_nxt;
      last_grant_q <= last_grant_nxt;
      op_q         <= op_nxt;
    end
  end

  // Next-state and latch update
  always_comb begin
    state_nxt      = state;
    winner_nxt     = winner_q;
    last_grant_nxt = last_grant_q;
    op_nxt         = op_q;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          winner_nxt = grant;
          op_nxt     = (grant == REQ1) ? op1 : op0;
          state_nxt  = ISSUE;
        end
      end
      ISSUE: state_nxt = RESP;
      RESP: begin
        state_nxt      = IDLE;
        last_grant_nxt = winner_q;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Port drive decodes straight from state so a reset in ISSUE kills the write at once
  assign bus.mem_write   = (state == ISSUE) && op_q.we;
  assign bus.mem_address = op_q.addr;
  assign bus.mem_data_in = op_q.wdata;
  assign bus.ack0        = (state == RESP) && (winner_q == REQ0);
  assign bus.ack1        = (state == RESP) && (winner_q == REQ1);
  assign bus.rdata       = bus.mem_data_out;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter with a behavioural 8x4 synchronous memory.
module tb_memory_arbiter;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;

  memory_arbiter_if bus ();

  memory_arbiter dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Write-first synchronous memory; contents survive arbiter reset
  logic [3:0] mem [8];
  logic [3:0] mem_q;
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 4'h0;
    mem_q = 4'h0;
  end
  always @(posedge clock) begin
    if (bus.mem_write) begin
      mem[bus.mem_address] <= bus.mem_data_in;
      mem_q                <= bus.mem_data_in;
    end else begin
      mem_q <= mem[bus.mem_address];
    end
  end
  assign bus.mem_data_out = mem_q;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Protocol invariants every cycle
  always @(negedge clock) begin
    checks++;
    if ((bus.ack0 && bus.ack1) || ((bus.ack0 || bus.ack1) && !bus.busy)) begin
      failures++;
      $display("FAIL ack_invariant: ack0=%0b ack1=%0b busy=%0b", bus.ack0, bus.ack1, bus.busy);
    end
  end

  // Call at a negedge with the arbiter idle; returns one negedge after the ack
  task automatic do_txn(input bit sel, input bit we, input logic [2:0] addr,
                        input logic [3:0] wd, output logic [3:0] rd,
                        output int lat, output int wcnt);
    bit got;
    got = 1'b0; lat = 0; wcnt = 0; rd = 4'h0;
    if (sel) begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd;
    end else begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd;
    end
    for (int i = 1; i <= 10 && !got; i++) begin
      @(negedge clock);
      if (bus.mem_write) wcnt++;
      if (sel ? bus.ack1 : bus.ack0) begin
        got = 1'b1;
        lat = i + 1;
        rd  = bus.rdata;
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    if (!got) chk("txn_ack_timeout", 0, 1);
    @(negedge clock);
  endtask

  task automatic check_idle(input string name);
    chk({name, "_ack0"}, int'(bus.ack0), 0);
    chk({name, "_ack1"}, int'(bus.ack1), 0);
    chk({name, "_busy"}, int'(bus.busy), 0);
    chk({name, "_mem_write"}, int'(bus.mem_write), 0);
  endtask

  typedef struct {
    bit         sel;
    bit         we;
    logic [2:0] addr;
    logic [3:0] wd;
    logic [3:0] exp_rd;
  } vec_t;

  vec_t       vecs [8];
  logic [3:0] rd;
  int         lat;
  int         wcnt;
  int         nacks;
  bit         order [4];
  logic [3:0] tie_rd [4];
  int         t_first;
  int         t_second;
  int         n_ack1;
  int         n_ack0;

  initial begin
    checks = 0; failures = 0;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = 3'd0; bus.addr1 = 3'd0; bus.wdata0 = 4'h0; bus.wdata1 = 4'h0;

    vecs[0] = '{sel: 1'b0, we: 1'b1, addr: 3'd5, wd: 4'hA, exp_rd: 4'hA};
    vecs[1] = '{sel: 1'b0, we: 1'b0, addr: 3'd5, wd: 4'h0, exp_rd: 4'hA};
    vecs[2] = '{sel: 1'b1, we: 1'b1, addr: 3'd0, wd: 4'h7, exp_rd: 4'h7};
    vecs[3] = '{sel: 1'b0, we: 1'b0, addr: 3'd0, wd: 4'h0, exp_rd: 4'h7};
    vecs[4] = '{sel: 1'b1, we: 1'b0, addr: 3'd7, wd: 4'h0, exp_rd: 4'h0};
    vecs[5] = '{sel: 1'b0, we: 1'b1, addr: 3'd7, wd: 4'hC, exp_rd: 4'hC};
    vecs[6] = '{sel: 1'b1, we: 1'b0, addr: 3'd7, wd: 4'h0, exp_rd: 4'hC};
    vecs[7] = '{sel: 1'b1, we: 1'b1, addr: 3'd2, wd: 4'h3, exp_rd: 4'h3};

    // Reset held two cycles, then idle with no requests
    reset_n = 1'b0;
    @(negedge clock); check_idle("rst_c1");
    @(negedge clock); check_idle("rst_c2");
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); check_idle("idle");
    end

    // Single-requester transactions
    foreach (vecs[i]) begin
      do_txn(vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].wd, rd, lat, wcnt);
      chk($sformatf("vec%0d_rdata", i), int'(rd), int'(vecs[i].exp_rd));
      chk($sformatf("vec%0d_latency", i), lat, 3);
      chk($sformatf("vec%0d_write_cycles", i), wcnt, vecs[i].we ? 1 : 0);
    end

    // Tie: both held from a fresh reset; requester 0 reads addr 5, requester 1 writes 3 to addr 2
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 3'd5;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 3'd2; bus.wdata1 = 4'h3;
    nacks = 0;
    for (int i = 0; i < 20 && nacks < 4; i++) begin
      @(negedge clock);
      if (bus.ack0 || bus.ack1) begin
        order[nacks]  = bus.ack1;
        tie_rd[nacks] = bus.rdata;
        nacks++;
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    chk("tie_ack_count", nacks, 4);
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      chk($sformatf("tie_order%0d", i), int'(order[i]), i % 2);
      chk($sformatf("tie_rdata%0d", i), int'(tie_rd[i]), (i % 2 == 1) ? 3 : 10);
`else
      chk($sformatf("tie_order%0d", i), int'(order[i]), 0);
      chk($sformatf("tie_rdata%0d", i), int'(tie_rd[i]), 10);
`endif
    end
    @(negedge clock);
    do_txn(1'b1, 1'b1, 3'd2, 4'h3, rd, lat, wcnt);
    chk("tie_req1_after_rdata", int'(rd), 3);

    // Reset asserted during ISSUE of a write to addr 3
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 3'd3; bus.wdata0 = 4'hF;
    @(negedge clock);
    chk("rst_issue_write_seen", int'(bus.mem_write), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_issue_write_drop", int'(bus.mem_write), 0);
    chk("rst_issue_busy", int'(bus.busy), 0);
    bus.req0 = 1'b0;
    @(negedge clock);
    check_idle("rst_issue_after");
    reset_n = 1'b1;
    @(negedge clock);
    check_idle("rst_issue_release");
    do_txn(1'b0, 1'b0, 3'd3, 4'h0, rd, lat, wcnt);
    chk("rst_issue_addr3", int'(rd), 0);
    chk("rst_issue_read_lat", lat, 3);

    // Back-to-back: req1 held through the IDLE cycle after its ack
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 3'd2;
    n_ack1 = 0; n_ack0 = 0; t_first = 0; t_second = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (bus.ack0) n_ack0++;
      if (bus.ack1) begin
        n_ack1++;
        chk($sformatf("b2b_rdata%0d", n_ack1), int'(bus.rdata), 3);
        if (n_ack1 == 1) t_first = c;
        else t_second = c;
      end
      if (t_first != 0 && c == t_first + 2) bus.req1 = 1'b0;
    end
    bus.req1 = 1'b0;
    chk("b2b_ack1_count", n_ack1, 2);
    chk("b2b_ack_spacing", t_second - t_first, 3);
    chk("b2b_ack0_count", n_ack0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
